// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD register-window controller:
// FSM encoding, HD44780 init ROM, status bit positions.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_ENABLE,
    ST_HOLD,
    ST_EXEC_WAIT
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_word_t;

  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    8'h01, 8'h06, 8'h0C, 8'h38
  };

  localparam int BIT_BUSY = 0;
  localparam int BIT_FULL = 1;
  localparam int BIT_OVF  = 2;

  localparam logic [7:0] CLR_LO = 8'h01;
  localparam logic [7:0] CLR_HI = 8'h03;

  function automatic logic is_clr_home(input lcd_word_t w);
    return !w.rs && (w.data >= CLR_LO) && (w.data <= CLR_HI);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command/data word queue between the LSU write port and the LCD bus FSM.
// Pointers carry an extra wrap bit so full and empty are exact.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             do_push;
  logic             do_pop;

  assign full = (wp[AW] != rp[AW]) &&
                (wp[AW-1:0] == rp[AW-1:0]);
  assign empty   = (wp == rp);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lcd_controller.sv
// HD44780 driver behind the LSU LCD window: power-on init, then replays
// queued command/data words with setup/enable/hold/exec timing.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PWR_CYC    = 750000,
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 12,
  parameter int HOLD_CYC   = 1,
  parameter int EXEC_CYC   = 2000,
  parameter int CLR_CYC    = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_status,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on
);

  localparam int T_MAX = (PWR_CYC > CLR_CYC) ?
                         PWR_CYC : CLR_CYC;
  localparam int TW = $clog2(T_MAX + 1);
  localparam int IW = $clog2(INIT_LEN + 1);
  localparam int RW = $clog2(INIT_LEN);

  lcd_state_e    state;
  lcd_state_e    state_d;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_d;
  logic [IW-1:0] init_idx;
  lcd_word_t     bus_q;
  lcd_word_t     word_d;
  lcd_word_t     head;
  logic          load;
  logic          pop;
  logic          init_step;
  logic          en_q;
  logic          on_q;
  logic          ovf_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          busy;
  logic          done;
  logic          unused_wr;

  // Durations are zero-based: a load of n-1 gives n clocks in the state.
  function automatic logic [TW-1:0] ld(input int n);
    return TW'(n - 1);
  endfunction

  assign push      = i_wr_en && !fifo_full;
  assign done      = (tmr == '0);
  assign unused_wr = &{1'b0, i_wr_data[30:9]};

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(lcd_word_t))
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (i_wr_data[8:0]),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state;
    tmr_d     = done ? tmr : tmr - 1'b1;
    word_d    = bus_q;
    load      = 1'b0;
    pop       = 1'b0;
    init_step = 1'b0;
    unique case (state)
      ST_PWR_WAIT: begin
        if (done) begin
          init_step   = 1'b1;
          load        = 1'b1;
          word_d.rs   = 1'b0;
          word_d.data = INIT_ROM[0];
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          load   = 1'b1;
          word_d = head;
        end
      end
      ST_SETUP: begin
        if (done) begin
          state_d = ST_ENABLE;
          tmr_d   = ld(EN_CYC);
        end
      end
      ST_ENABLE: begin
        if (done) begin
          state_d = ST_HOLD;
          tmr_d   = ld(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (done) begin
          state_d = ST_EXEC_WAIT;
          tmr_d   = is_clr_home(bus_q) ?
                    ld(CLR_CYC) : ld(EXEC_CYC);
        end
      end
      ST_EXEC_WAIT: begin
        if (done) begin
          if (init_idx < IW'(INIT_LEN)) begin
            init_step   = 1'b1;
            load        = 1'b1;
            word_d.rs   = 1'b0;
            word_d.data = INIT_ROM[init_idx[RW-1:0]];
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            load   = 1'b1;
            word_d = head;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
    if (load) begin
      state_d = ST_SETUP;
      tmr_d   = ld(SETUP_CYC);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_PWR_WAIT;
      tmr      <= ld(PWR_CYC);
      init_idx <= '0;
      bus_q    <= '0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
      bus_q <= word_d;
      en_q  <= (state_d == ST_ENABLE);
      if (init_step) init_idx <= init_idx + 1'b1;
      if (push) on_q <= i_wr_data[31];
      if (i_wr_en && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    o_status           = '0;
    o_status[BIT_BUSY] = busy;
    o_status[BIT_FULL] = fifo_full;
    o_status[BIT_OVF]  = ovf_q;
  end

  assign o_lcd_data = bus_q.data;
  assign o_lcd_rs   = bus_q.rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller: table of single writes, corner sequences and
// random bursts checked against a transaction-level model of the LCD bus.
module tb_lcd_controller;

  localparam int PWR = 100;
  localparam int SET = 2;
  localparam int ENC = 4;
  localparam int HLD = 1;
  localparam int EXE = 20;
  localparam int CLR = 50;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] status;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;

  lcd_controller #(
    .FIFO_DEPTH (DEP),
    .PWR_CYC    (PWR),
    .SETUP_CYC  (SET),
    .EN_CYC     (ENC),
    .HOLD_CYC   (HLD),
    .EXEC_CYC   (EXE),
    .CLR_CYC    (CLR)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_status   (status),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  // Expected execution time of one word on the panel
  function automatic int exec_of(input logic [8:0] w);
    return (!w[8] && w[7:0] >= 8'h01 && w[7:0] <= 8'h03) ? CLR : EXE;
  endfunction

  // Bus monitor: records every EN pulse and busy falling edge
  int         rise_c[$];
  int         fall_c[$];
  int         busy_fall[$];
  logic [8:0] pw_q[$];
  logic [8:0] h1 = '0;
  logic [8:0] h2 = '0;
  logic [8:0] pw = '0;
  logic       en_p = 1'b0;
  logic       busy_p = 1'b1;
  logic       stab = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      en_p = 1'b0;
      busy_p = 1'b1;
    end else begin
      if (lcd_en && !en_p) begin
        pw = {lcd_rs, lcd_data};
        stab = (h1 == pw) && (h2 == pw);
        rise_c.push_back(cyc);
        pw_q.push_back(pw);
      end else if (lcd_en && ({lcd_rs, lcd_data} != pw)) begin
        stab = 1'b0;
      end
      if (!lcd_en && en_p) begin
        chk("bus_stable", 32'(stab && ({lcd_rs, lcd_data} == pw)), 1);
        fall_c.push_back(cyc);
      end
      if (!status[0] && busy_p) busy_fall.push_back(cyc);
      en_p = lcd_en;
      busy_p = status[0];
    end
    h2 = h1;
    h1 = {lcd_rs, lcd_data};
  end

  task automatic clear_mon();
    rise_c.delete();
    fall_c.delete();
    busy_fall.delete();
    pw_q.delete();
  endtask

  int rel;

  task automatic do_reset();
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    clear_mon();
  endtask

  logic [31:0] bw[8];
  int bn;
  int wcyc;

  task automatic burst();
    for (int i = 0; i < bn; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = bw[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
    wcyc = cyc;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    logic ok;
    k = 0;
    ok = 1'b0;
    while (!ok && k < budget) begin
      @(negedge clk);
      #1;
      k++;
      ok = rise_c.size() >= n && fall_c.size() >= n && !status[0];
    end
    chk("wait_done", 32'(ok), 1);
  endtask

  task automatic verify(input string tag, input logic [8:0] exp[$]);
    int n;
    n = exp.size();
    wait_done(n, 6000);
    chk({tag, "_count"}, rise_c.size(), n);
    for (int i = 0; i < n && i < rise_c.size() && i < fall_c.size(); i++) begin
      chk({tag, "_word"}, 32'(pw_q[i]), 32'(exp[i]));
      chk({tag, "_en_width"}, fall_c[i] - rise_c[i], ENC);
      if (i > 0)
        chk({tag, "_gap"}, rise_c[i] - fall_c[i-1],
            HLD + exec_of(exp[i-1]) + SET);
    end
    if (busy_fall.size() > 0 && fall_c.size() > 0)
      chk({tag, "_busy_drop"}, busy_fall[$] - fall_c[$],
          HLD + exec_of(exp[n-1]));
    else
      chk({tag, "_busy_seen"}, busy_fall.size(), 1);
    clear_mon();
  endtask

  typedef struct {
    logic [31:0] w;
    logic        rs;
    logic [7:0]  d;
    logic        on;
    int          ex;
  } vec_t;

  vec_t       tv[9];
  logic [8:0] init_q[$];
  logic [8:0] exp_q[$];
  logic       on_m;
  logic       ovf_m;
  int         tgt;

  initial begin
    tv[0] = '{32'h8000_0141, 1'b1, 8'h41, 1'b1, EXE};
    tv[1] = '{32'h0000_0001, 1'b0, 8'h01, 1'b0, CLR};
    tv[2] = '{32'h8000_0002, 1'b0, 8'h02, 1'b1, CLR};
    tv[3] = '{32'h0000_0003, 1'b0, 8'h03, 1'b0, CLR};
    tv[4] = '{32'h0000_0004, 1'b0, 8'h04, 1'b0, EXE};
    tv[5] = '{32'h0000_0000, 1'b0, 8'h00, 1'b0, EXE};
    tv[6] = '{32'h0000_0101, 1'b1, 8'h01, 1'b0, EXE};
    tv[7] = '{32'h7FFF_FE55, 1'b0, 8'h55, 1'b0, EXE};
    tv[8] = '{32'hFFFF_FF03, 1'b1, 8'h03, 1'b1, EXE};
    init_q = '{9'h038, 9'h00C, 9'h006, 9'h001};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_status", status, 32'h1);
    chk("rst_en", 32'(lcd_en), 0);
    chk("rst_rs", 32'(lcd_rs), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_on", 32'(lcd_on), 0);
    chk("rw_tied", 32'(lcd_rw), 0);
    rst_n = 1'b1;
    rel = cyc;

    // Power-on init with no writes
    wait_done(4, 2000);
    if (rise_c.size() > 0)
      chk("first_rise", rise_c[0] - rel, PWR + SET);
    verify("init", init_q);

    // Single writes from idle
    foreach (tv[v]) begin
      bw[0] = tv[v].w;
      bn = 1;
      burst();
      chk("tv_on", 32'(lcd_on), 32'(tv[v].on));
      wait_done(1, 400);
      if (rise_c.size() > 0 && fall_c.size() > 0 && busy_fall.size() > 0) begin
        chk("tv_rs", 32'(pw_q[0][8]), 32'(tv[v].rs));
        chk("tv_data", 32'(pw_q[0][7:0]), 32'(tv[v].d));
        chk("tv_latency", rise_c[0] - wcyc, 1 + SET);
        chk("tv_en_width", fall_c[0] - rise_c[0], ENC);
        chk("tv_busy_drop", busy_fall[$] - fall_c[0], HLD + tv[v].ex);
      end else begin
        chk("tv_pulse_seen", rise_c.size(), 1);
      end
      clear_mon();
    end

    // Clear followed by data: long then short exec wait
    bw[0] = 32'h0000_0001;
    bw[1] = 32'h0000_0141;
    bn = 2;
    burst();
    exp_q = '{9'h001, 9'h141};
    verify("clr_data", exp_q);

    // Random bursts from idle; one word leaves immediately, DEP more queue
    ovf_m = 1'b0;
    on_m = lcd_on;
    for (int r = 0; r < 12; r++) begin
      bn = $urandom_range(1, 6);
      exp_q.delete();
      for (int i = 0; i < bn; i++) begin
        bw[i] = $urandom;
        if ($urandom_range(0, 3) == 0)
          bw[i][8:0] = {1'b0, 8'($urandom_range(1, 3))};
        if (i < DEP + 1) begin
          exp_q.push_back(bw[i][8:0]);
          on_m = bw[i][31];
        end else begin
          ovf_m = 1'b1;
        end
      end
      burst();
      chk("rnd_on", 32'(lcd_on), 32'(on_m));
      verify("rnd", exp_q);
      chk("rnd_ovf", 32'(status[2]), 32'(ovf_m));
    end

    // Push on the same cycle as a pop with DEPTH-1 words queued
    do_reset();
    verify("init2", init_q);
    bw[0] = 32'h0000_0041;
    bw[1] = 32'h0000_0142;
    bw[2] = 32'h0000_0043;
    bw[3] = 32'h0000_0144;
    bn = 4;
    burst();
    for (int k = 0; k < 300 && fall_c.size() == 0; k++) @(negedge clk);
    #1;
    if (fall_c.size() == 0) begin
      chk("pp_first_fall", 0, 1);
    end else begin
      tgt = fall_c[0] + HLD + EXE;
      while (cyc < tgt - 1) @(negedge clk);
      chk("pp_full_before", 32'(status[1]), 0);
      wr_en = 1'b1;
      wr_data = 32'h0000_0155;
      @(negedge clk);
      wr_en = 1'b0;
      chk("pp_pop_now", 32'({lcd_rs, lcd_data}), 32'h142);
      chk("pp_full_after", 32'(status[1]), 0);
    end
    exp_q = '{9'h041, 9'h142, 9'h043, 9'h144, 9'h155};
    verify("pushpop", exp_q);
    chk("pp_ovf", 32'(status[2]), 0);

    // Six writes during power-on wait: four queue, two drop
    do_reset();
    bw[0] = 32'h0000_0150;
    bw[1] = 32'h8000_0051;
    bw[2] = 32'h0000_0152;
    bw[3] = 32'h0000_0053;
    bw[4] = 32'h8000_0154;
    bw[5] = 32'h8000_0055;
    bn = 6;
    burst();
    chk("pw_full", 32'(status[1]), 1);
    chk("pw_ovf", 32'(status[2]), 1);
    chk("pw_on", 32'(lcd_on), 0);
    exp_q = init_q;
    for (int i = 0; i < DEP; i++) exp_q.push_back(bw[i][8:0]);
    verify("pw_burst", exp_q);
    chk("pw_ovf_sticky", 32'(status[2]), 1);
    chk("pw_full_clr", 32'(status[1]), 0);

    // Reset in the middle of an EN pulse
    do_reset();
    bw[0] = 32'h8000_0161;
    bw[1] = 32'h8000_0162;
    bn = 2;
    burst();
    for (int k = 0; k < 400 && rise_c.size() == 0; k++) @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid_en_high", 32'(lcd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(lcd_en), 0);
    chk("mid_rst_status", status, 32'h1);
    chk("mid_rst_on", 32'(lcd_on), 0);
    chk("mid_rst_data", 32'(lcd_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    verify("restart", init_q);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
